// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB over one
// shared memory port and one ALU, with a sticky TRAP for illegal/system opcodes.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] op_type,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic [2:0] state,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       mdr_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [1:0] alu_a_sel,
  output logic       alu_b_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       halted
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXECUTE = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;
  localparam logic [2:0] S_TRAP    = 3'd5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  logic [2:0] state_next;
  logic       legal;
  logic       is_store;

  // Unknown opcodes decode as type I, so classification relies on the opcode alone.
  logic unused_op_type;
  assign unused_op_type = ^op_type;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE: legal = 1'b1;
      default:                                     legal = 1'b0;
    endcase
  end

  assign is_store = (opcode == OP_STORE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    mdr_we     = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    alu_a_sel  = 2'd0;
    alu_b_sel  = 1'b0;
    rf_we      = 1'b0;
    wb_sel     = 2'd0;
    retire     = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: state_next = legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        case (opcode)
          OP_R:     state_next = S_WB;
          OP_IMM:   begin alu_b_sel = 1'b1; state_next = S_WB;  end
          OP_LOAD:  begin alu_b_sel = 1'b1; state_next = S_MEM; end
          OP_STORE: begin alu_b_sel = 1'b1; state_next = S_MEM; end
          OP_LUI:   begin alu_a_sel = 2'd2; alu_b_sel = 1'b1; state_next = S_WB; end
          OP_AUIPC: begin alu_a_sel = 2'd1; alu_b_sel = 1'b1; state_next = S_WB; end
          OP_JAL:   state_next = S_WB;
          OP_JALR:  begin alu_b_sel = 1'b1; state_next = S_WB;  end
          OP_BRANCH: begin
            pc_we      = 1'b1;
            pc_src     = branch_taken ? 2'd1 : 2'd0;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          OP_FENCE: begin
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          default:  state_next = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            mdr_we     = 1'b1;
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        retire     = 1'b1;
        pc_we      = 1'b1;
        state_next = S_FETCH;
        case (opcode)
          OP_LOAD: wb_sel = 2'd1;
          OP_JAL:  begin wb_sel = 2'd2; pc_src = 2'd1; end
          OP_JALR: begin wb_sel = 2'd2; pc_src = 2'd2; end
          default: wb_sel = 2'd0;
        endcase
      end
      S_TRAP:  halted = 1'b1;
      default: state_next = S_FETCH;
    endcase
    // Enables drop in the reset cycle itself, even mid-access.
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      mdr_we  = 1'b0;
      pc_we   = 1'b0;
      rf_we   = 1'b0;
      retire  = 1'b0;
    end
  end

endmodule
